// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types, constants and helpers for the Tuse/Tnew hazard scoreboard
// Records are stored at fixed maximum widths so every instance of any AW/TW up to these limits shares one type.
package hazard_pkg;

    localparam int AW_MAX = 8;
    localparam int TW_MAX = 4;

    typedef logic [AW_MAX-1:0] reg_addr_t;
    typedef logic [TW_MAX-1:0] timing_t;
    typedef logic [1:0]        fwd_sel_t;

    localparam timing_t  TUSE_NONE = timing_t'(3);

    localparam fwd_sel_t FWD_RF = 2'd0;
    localparam fwd_sel_t FWD_E  = 2'd1;
    localparam fwd_sel_t FWD_M  = 2'd2;
    localparam fwd_sel_t FWD_W  = 2'd3;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t a3;
        timing_t   tnew;
        logic      md_start;
        logic      md_is_div;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

    function automatic stage_rec_t age_rec(input stage_rec_t r);
        stage_rec_t a;
        a = r;
        if (a.tnew != '0) begin
            a.tnew = a.tnew - timing_t'(1);
        end
        return a;
    endfunction

    function automatic logic rec_hit(input logic valid, input reg_addr_t a3, input reg_addr_t src);
        return valid && (src != '0) && (a3 == src);
    endfunction

    // hit/rdy bit 2 = E, bit 1 = M, bit 0 = W; only the youngest hit is considered
    function automatic fwd_sel_t pick_fwd(input logic [2:0] hit, input logic [2:0] rdy);
        if (hit[2]) begin
            return rdy[2] ? FWD_E : FWD_RF;
        end else if (hit[1]) begin
            return rdy[1] ? FWD_M : FWD_RF;
        end else if (hit[0]) begin
            return rdy[0] ? FWD_W : FWD_RF;
        end
        return FWD_RF;
    endfunction

    function automatic logic data_stall(input logic [1:0] hit_em, input timing_t tn_e,
                                        input timing_t tn_m, input timing_t tuse);
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end else if (hit_em[1]) begin
            return tn_e > tuse;
        end else if (hit_em[0]) begin
            return tn_m > tuse;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage request and hazard response bundle
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 2
);

    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [AW-1:0] d_a3;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_is_div;
    logic          d_md_use;

    logic          stall;
    logic [1:0]    fwd_rs_d;
    logic [1:0]    fwd_rt_d;
    logic [1:0]    fwd_rs_e;
    logic [1:0]    fwd_rt_e;
    logic [1:0]    fwd_rt_m;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
               d_md_start, d_md_is_div, d_md_use,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
               d_md_start, d_md_is_div, d_md_use,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// rtl/hazard_scoreboard_md_busy_counter.sv - HI/LO busy tracking for multiply/divide
module md_busy_counter #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_e_md_start,
    input  logic i_e_md_is_div,
    output logic o_md_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] r_cnt;

    // A new md op can only reach E once the previous one has drained, so a load never clobbers a live count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_e_md_start) begin
            r_cnt <= i_e_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_md_busy = i_e_md_start || (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew hazard unit: shadow E/M/W records, stall and forward selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave hz
);

    logic [AW-1:0] w_d_rs;
    logic [AW-1:0] w_d_rt;
    logic [AW-1:0] w_d_a3;
    logic [TW-1:0] w_d_tuse_rs;
    logic [TW-1:0] w_d_tuse_rt;
    logic [TW-1:0] w_d_tnew;

    stage_rec_t r_e;
    stage_rec_t r_m;
    stage_rec_t r_w;
    stage_rec_t w_d_rec;

    logic [2:0] w_rdy;
    logic [2:0] w_hit_rs_d;
    logic [2:0] w_hit_rt_d;
    logic [1:0] w_hit_rs_e;
    logic [1:0] w_hit_rt_e;
    logic       w_hit_rt_m;

    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall;
    logic       w_md_busy;
    logic       w_unused;

    assign w_d_rs      = hz.d_rs;
    assign w_d_rt      = hz.d_rt;
    assign w_d_a3      = hz.d_a3;
    assign w_d_tuse_rs = hz.d_tuse_rs;
    assign w_d_tuse_rt = hz.d_tuse_rt;
    assign w_d_tnew    = hz.d_tnew;

    always_comb begin
        w_d_rec           = STAGE_BUBBLE;
        w_d_rec.valid     = hz.d_valid;
        w_d_rec.rs        = reg_addr_t'(w_d_rs);
        w_d_rec.rt        = reg_addr_t'(w_d_rt);
        w_d_rec.a3        = reg_addr_t'(w_d_a3);
        w_d_rec.tnew      = timing_t'(w_d_tnew);
        w_d_rec.md_start  = hz.d_md_start;
        w_d_rec.md_is_div = hz.d_md_is_div;
    end

    assign w_rdy = {r_e.tnew == '0, r_m.tnew == '0, r_w.tnew == '0};

    assign w_hit_rs_d = {rec_hit(r_e.valid, r_e.a3, w_d_rec.rs),
                         rec_hit(r_m.valid, r_m.a3, w_d_rec.rs),
                         rec_hit(r_w.valid, r_w.a3, w_d_rec.rs)};
    assign w_hit_rt_d = {rec_hit(r_e.valid, r_e.a3, w_d_rec.rt),
                         rec_hit(r_m.valid, r_m.a3, w_d_rec.rt),
                         rec_hit(r_w.valid, r_w.a3, w_d_rec.rt)};
    assign w_hit_rs_e = {rec_hit(r_m.valid, r_m.a3, r_e.rs),
                         rec_hit(r_w.valid, r_w.a3, r_e.rs)};
    assign w_hit_rt_e = {rec_hit(r_m.valid, r_m.a3, r_e.rt),
                         rec_hit(r_w.valid, r_w.a3, r_e.rt)};
    assign w_hit_rt_m = rec_hit(r_w.valid, r_w.a3, r_m.rt);

    assign hz.fwd_rs_d = pick_fwd(w_hit_rs_d, w_rdy);
    assign hz.fwd_rt_d = pick_fwd(w_hit_rt_d, w_rdy);
    assign hz.fwd_rs_e = pick_fwd({1'b0, w_hit_rs_e}, w_rdy);
    assign hz.fwd_rt_e = pick_fwd({1'b0, w_hit_rt_e}, w_rdy);
    assign hz.fwd_rt_m = pick_fwd({2'b00, w_hit_rt_m}, w_rdy);

    // A W producer never stalls: its result is always ready by then.
    assign w_stall_rs = data_stall(w_hit_rs_d[2:1], r_e.tnew, r_m.tnew, timing_t'(w_d_tuse_rs));
    assign w_stall_rt = data_stall(w_hit_rt_d[2:1], r_e.tnew, r_m.tnew, timing_t'(w_d_tuse_rt));
    assign w_stall    = hz.d_valid && (w_stall_rs || w_stall_rt || (hz.d_md_use && w_md_busy));

    assign hz.stall   = w_stall;
    assign hz.md_busy = w_md_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= STAGE_BUBBLE;
            r_m <= STAGE_BUBBLE;
            r_w <= STAGE_BUBBLE;
        end else begin
            r_e <= (hz.d_valid && !w_stall) ? w_d_rec : STAGE_BUBBLE;
            r_m <= age_rec(r_e);
            r_w <= age_rec(r_m);
        end
    end

    md_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_counter (
        .clk           (clk),
        .reset         (reset),
        .i_e_md_start  (r_e.valid && r_e.md_start),
        .i_e_md_is_div (r_e.md_is_div),
        .o_md_busy     (w_md_busy)
    );

    // Fields kept for record completeness but not consumed by any comparison.
    assign w_unused = ^{r_m.rs, r_m.md_start, r_m.md_is_div,
                        r_w.rs, r_w.rt, r_w.md_start, r_w.md_is_div};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic clk;
    logic reset;

    hazard_scoreboard_if #(.AW(5), .TW(2)) hz ();

    hazard_scoreboard #(
        .AW      (5),
        .TW      (2),
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        string name;
        int    stall;
        int    frsd;
        int    frtd;
        int    frse;
        int    frte;
        int    frtm;
        int    busy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        if (exp >= 0) begin
            n_checks++;
            if (act != exp) begin
                n_errors++;
                $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk(cur.name, "stall",    int'(hz.stall),    cur.stall);
            chk(cur.name, "fwd_rs_d", int'(hz.fwd_rs_d), cur.frsd);
            chk(cur.name, "fwd_rt_d", int'(hz.fwd_rt_d), cur.frtd);
            chk(cur.name, "fwd_rs_e", int'(hz.fwd_rs_e), cur.frse);
            chk(cur.name, "fwd_rt_e", int'(hz.fwd_rt_e), cur.frte);
            chk(cur.name, "fwd_rt_m", int'(hz.fwd_rt_m), cur.frtm);
            chk(cur.name, "md_busy",  int'(hz.md_busy),  cur.busy);
        end
    end

    task automatic set_d(input int v, input int rs, input int rt, input int tus, input int tut,
                         input int a3, input int tn, input int ms, input int mdiv, input int muse);
        hz.d_valid     = 1'(v);
        hz.d_rs        = 5'(rs);
        hz.d_rt        = 5'(rt);
        hz.d_tuse_rs   = 2'(tus);
        hz.d_tuse_rt   = 2'(tut);
        hz.d_a3        = 5'(a3);
        hz.d_tnew      = 2'(tn);
        hz.d_md_start  = 1'(ms);
        hz.d_md_is_div = 1'(mdiv);
        hz.d_md_use    = 1'(muse);
    endtask

    task automatic d_nop();
        set_d(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic d_md(input int is_div);
        set_d(1, 1, 2, 1, 1, 0, 0, 1, is_div, 1);
    endtask

    task automatic d_mflo();
        set_d(1, 0, 0, 3, 3, 9, 1, 0, 0, 1);
    endtask

    // Push this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input int st, input int frsd, input int frtd,
                       input int frse, input int frte, input int frtm, input int busy);
        exp_t e;
        e.name  = nm;
        e.stall = st;
        e.frsd  = frsd;
        e.frtd  = frtd;
        e.frse  = frse;
        e.frte  = frte;
        e.frtm  = frtm;
        e.busy  = busy;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        d_mflo();
        @(posedge clk);
        #1;
        cyc("rst_hold", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        set_d(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); cyc("add3",        0, 0, 0, 0, 0, 0, 0);
        set_d(1, 3, 5, 0, 0, 0, 0, 0, 0, 0); cyc("beq_stall",   1, 0, 0, 0, 0, 0, 0);
                                             cyc("beq_go",      0, 2, 0, 0, 0, 0, 0);
        d_nop();                             cyc("beq_in_e",    0, 0, 0, 3, 0, 0, 0);
                                             cyc("flush1",      0, 0, 0, 0, 0, 0, 0);

        set_d(1, 1, 4, 1, 3, 4, 2, 0, 0, 0); cyc("lw4",         0, 0, 0, 0, 0, 0, 0);
        set_d(1, 4, 7, 1, 1, 6, 1, 0, 0, 0); cyc("lw_use_stall",1, 0, 0, 0, 0, 0, 0);
                                             cyc("lw_use_go",   0, 0, 0, 0, 0, 0, 0);
        set_d(1, 1, 6, 1, 2, 0, 0, 0, 0, 0); cyc("sw_in_d",     0, 0, 0, 3, 0, 0, 0);
        d_nop();                             cyc("sw_in_e",     0, 0, 0, 0, 2, 0, 0);
                                             cyc("sw_in_m",     0, 0, 0, 0, 0, 3, 0);

        set_d(1, 0, 0, 3, 3, 31, 0, 0, 0, 0); cyc("jal",        0, 0, 0, 0, 0, 0, 0);
        set_d(1, 31, 0, 0, 3, 0, 0, 0, 0, 0); cyc("jr_fwd_e",   0, 1, 0, 0, 0, 0, 0);
        d_nop();                              cyc("jr_in_e",    0, 0, 0, 2, 0, 0, 0);

        set_d(1, 1, 2, 1, 1, 0, 1, 0, 0, 0); cyc("add_r0",      0, 0, 0, 0, 0, 0, 0);
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("beq_r0",      0, 0, 0, 0, 0, 0, 0);
        d_nop();                             cyc("r0_in_e",     0, 0, 0, 0, 0, 0, 0);

        set_d(1, 1, 8, 1, 3, 8, 2, 0, 0, 0); cyc("lw8",         0, 0, 0, 0, 0, 0, 0);
        set_d(0, 8, 8, 0, 0, 0, 0, 0, 0, 0); cyc("bubble_nostall", 0, 0, 0, 0, 0, 0, 0);
        set_d(1, 0, 8, 3, 0, 0, 0, 0, 0, 0); cyc("rt_stall_m",  1, 0, 0, 0, 0, 0, 0);
                                             cyc("rt_fwd_w",    0, 0, 3, 0, 0, 0, 0);
        d_nop();                             cyc("flush5",      0, 0, 0, 0, 0, 0, 0);

        d_md(1);  cyc("div_issue", 0, 0, 0, 0, 0, 0, 0);
        d_mflo();
        for (int i = 0; i < 11; i++) cyc("div_mflo_stall", 1, 0, 0, 0, 0, 0, 1);
        cyc("div_release", 0, 0, 0, 0, 0, 0, 0);
        d_nop();  cyc("mflo_in_e", 0, 0, 0, 0, 0, 0, 0);

        d_md(0);  cyc("mult_issue", 0, 0, 0, 0, 0, 0, 0);
        d_mflo();
        for (int i = 0; i < 6; i++) cyc("mult_mflo_stall", 1, 0, 0, 0, 0, 0, 1);
        cyc("mult_release", 0, 0, 0, 0, 0, 0, 0);
        d_nop();  cyc("mflo2_in_e", 0, 0, 0, 0, 0, 0, 0);

        d_md(1);  cyc("div2_issue", 0, 0, 0, 0, 0, 0, 0);
        d_mflo();
        for (int i = 0; i < 3; i++) cyc("div2_stall", 1, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        cyc("rst_mid_busy", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst_hold2",    0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("mflo_after_rst", 0, 0, 0, 0, 0, 0, 0);
        d_nop();
        cyc("final", 0, 0, 0, 0, 0, 0, 0);

        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d pending, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the five-stage MIPS pipeline. It replaces per-instruction-class comparison chains with Tuse/Tnew scheduling. The block keeps its own shadow records of the E, M and W pipeline stages and a multiply/divide busy counter. From these it produces the stall signal and every forwarding select. The decoder in D supplies each instruction's source/destination registers and timing figures; nothing else is decoded here.

## Interface

Parameters:
- AW, 5, register address width
- TW, 2, Tuse/Tnew field width
- MUL_LAT, 5, HI/LO busy cycles after mult/multu leaves E
- DIV_LAT, 10, HI/LO busy cycles after div/divu leaves E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- d_valid  in  1  D holds a real instruction (0 = bubble)
- d_rs, d_rt  in  AW  D source register addresses
- d_tuse_rs, d_tuse_rt  in  TW  stages until the operand is consumed: 0 = D, 1 = E, 2 = M, 3 = unused
- d_a3  in  AW  D destination register, 0 = none
- d_tnew  in  TW  cycles after E entry until the result exists: jal 0, cal_r/cal_i 1, load 2
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_is_div  in  1  qualifies d_md_start
- d_md_use  in  1  D reads or writes HI/LO (mfhi/mflo/mthi/mtlo/md start)
- stall  out  1  freeze PC and F/D, insert a bubble into E
- fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m  out  2  forward selects
- md_busy  out  1  HI/LO result pending

## Operation

- Each record in E, M and W holds: valid, rs, rt, a3, tnew, md_start, md_is_div.
- Every clock, the records shift:
  - M <= E and W <= M, with tnew decremented by 1 and saturating at 0.
  - E <= D fields when stall = 0.
  - E <= bubble (valid 0, a3 0, md_start 0) when stall = 1.
  - When d_valid = 0, E receives a bubble.
- Producer match for source s (s != 0):
  - Matching stages are the valid stages with a3 == s.
  - Only the youngest matching stage is considered (E before M before W).
- Data stall: asserted for a D source with tuse != 3 when the youngest match is E or M and its current tnew > tuse.
- HI/LO stall: asserted when d_valid && d_md_use && md_busy.
- stall = OR of all data stalls and the HI/LO stall, qualified by d_valid.
- md_busy = E.valid && E.md_start, OR counter != 0.
- Busy counter:
  - Loads DIV_LAT or MUL_LAT on the edge where a valid md_start record leaves E.
  - Otherwise decrements while nonzero.
  - Counter width is clog2(max(MUL_LAT, DIV_LAT) + 1).
- Forward encoding: 0 = register/pipeline value, 1 = E-stage result, 2 = M-stage result, 3 = W-stage result.
- Forward selects per consumer:
  - D consumers search E, M, W.
  - E consumers (E.rs, E.rt) search M, W.
  - The M consumer (M.rt, store data) searches W.
  - The select names the youngest matching stage only if its tnew == 0; otherwise it is 0, because a stall or a later cycle resolves the hazard.
- Register $0 never matches: no stall and no forward.

## Timing

- stall, all fwd_* and md_busy are combinational from the current records and D inputs; no added latency.
- Records update on the rising clk edge.
- Reset:
  - All records invalid, counter 0, asynchronously.
  - While reset is high, every output is 0.
  - When reset asserts in the middle of a stall or busy period, stall and md_busy drop immediately, with no residual state after release.
- Simultaneous events:
  - A D md_start with md_busy = 1 stalls, so the counter is never reloaded while nonzero.
  - Data stall and HI/LO stall may coincide; stall is simply their OR.
- Counter reaching 0 releases the stall in the same cycle the counter reads 0.

## Structure

- Package hazard_pkg holds:
  - TUSE_NONE = 3
  - FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3
  - the stage record typedef
- One sub-module, md_busy_counter (parameters MUL_LAT and DIV_LAT), owns the counter and md_busy.
- Record shifting, stall logic and forward logic stay in hazard_scoreboard.

## Test plan

- add $3 in E (tnew 1), D = beq reading $3 as rs (tuse 0) -> stall = 1 for exactly one cycle, then stall = 0 with fwd_rs_d = 2.
- lw $4 in E (tnew 2), D = add reading $4 as rs (tuse 1) -> one stall cycle; two cycles after the stall, fwd_rs_e = 3.
- jal in E, D = jr $31 -> stall = 0, fwd_rs_d = 1.
- Any producer with a3 = 0 followed by a consumer of $0 -> stall = 0 and all fwd_* = 0.
- div in E, then mflo in D, with DIV_LAT = 10 -> stall = 1 for 11 consecutive cycles. The same sequence with mult and MUL_LAT = 5 -> 6 cycles.
- reset pulsed during the div busy period -> stall = 0 and md_busy = 0 immediately. After release, an mflo proceeds without stalling.
